// File: rtl/sgt_pkg.sv
// Shared types for the bit-serial comparator.
// FSM state encoding and counter-width helper.
package sgt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sgt_state_t;

  // Width of the bit counter; N >= 2 so this is never below 1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_cmp_cell.sv
// One-bit update of the running greater/less flags.
// Ports: ai, bi (current bits), g_in, l_in (flags so far), g_out, l_out.
module bit_cmp_cell (
  input  logic ai,
  input  logic bi,
  input  logic g_in,
  input  logic l_in,
  output logic g_out,
  output logic l_out
);

  // A differing bit overrides whatever the less significant bits decided.
  always_comb begin
    g_out = g_in;
    l_out = l_in;
    unique case (1'b1)
      (ai & ~bi): begin
        g_out = 1'b1;
        l_out = 1'b0;
      end
      (~ai & bi): begin
        g_out = 1'b0;
        l_out = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_greater_than.sv
// LSB-first bit-serial unsigned comparator with start/ready and valid/ready handshakes.
// Ports: clk, reset (async high), start/a/b/ready in, res_valid/res_ready/gt/eq/lt out.
module serial_greater_than
  import sgt_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  sgt_state_t    r_state;
  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic          r_g;
  logic          r_l;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic          r_valid;
  logic          r_gt;
  logic          r_eq;
  logic          r_lt;

  logic          w_g_next;
  logic          w_l_next;

  bit_cmp_cell u_cell (
    .ai    (r_sa[0]),
    .bi    (r_sb[0]),
    .g_in  (r_g),
    .l_in  (r_l),
    .g_out (w_g_next),
    .l_out (w_l_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_g     <= 1'b0;
      r_l     <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sa <= r_sa >> 1;
          r_sb <= r_sb >> 1;
          r_g  <= w_g_next;
          r_l  <= w_l_next;
          // Counter stops at N-1 so it never wraps.
          if (r_cnt == LAST) begin
            r_gt    <= w_g_next;
            r_lt    <= w_l_next;
            r_eq    <= ~w_g_next & ~w_l_next;
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready     = r_ready;
  assign res_valid = r_valid;
  assign gt        = r_gt;
  assign eq        = r_eq;
  assign lt        = r_lt;

endmodule

// File: tb/tb_serial_greater_than.sv
// Directed bench for serial_greater_than at N=8, N=2 and N=16.
// Each task drives one scenario and checks inline against hand-computed values.
module tb_serial_greater_than;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int checks = 0;
  int errors = 0;

  logic       st8, rr8, rdy8, vld8, gt8, eq8, lt8;
  logic [7:0] a8, b8;
  logic       st2, rr2, rdy2, vld2, gt2, eq2, lt2;
  logic [1:0] a2, b2;
  logic        st16, rr16, rdy16, vld16, gt16, eq16, lt16;
  logic [15:0] a16, b16;

  serial_greater_than #(.N(8)) u8 (
    .clk(clk), .reset(rst), .start(st8), .a(a8), .b(b8),
    .ready(rdy8), .res_valid(vld8), .res_ready(rr8),
    .gt(gt8), .eq(eq8), .lt(lt8)
  );

  serial_greater_than #(.N(2)) u2 (
    .clk(clk), .reset(rst), .start(st2), .a(a2), .b(b2),
    .ready(rdy2), .res_valid(vld2), .res_ready(rr2),
    .gt(gt2), .eq(eq2), .lt(lt2)
  );

  serial_greater_than #(.N(16)) u16 (
    .clk(clk), .reset(rst), .start(st16), .a(a16), .b(b16),
    .ready(rdy16), .res_valid(vld16), .res_ready(rr16),
    .gt(gt16), .eq(eq16), .lt(lt16)
  );

  task automatic start8(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a8  = x;
    b8  = y;
    st8 = 1'b1;
    @(posedge clk);
    #1;
    st8 = 1'b0;
  endtask

  // Counts edges until res_valid; gives up after 20 so callers see a bad latency.
  task automatic wait8(output int lat);
    lat = 0;
    while (!vld8 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    st8 = 1'b0; rr8 = 1'b0; a8 = '0; b8 = '0;
    st2 = 1'b0; rr2 = 1'b0; a2 = '0; b2 = '0;
    st16 = 1'b0; rr16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdy8, vld8, gt8, eq8, lt8} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_n8 got=%b required=10000",
               {rdy8, vld8, gt8, eq8, lt8});
    end
    checks++;
    if ({rdy2, vld2, gt2, eq2, lt2} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_n2 got=%b required=10000",
               {rdy2, vld2, gt2, eq2, lt2});
    end
    checks++;
    if ({rdy16, vld16, gt16, eq16, lt16} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_n16 got=%b required=10000",
               {rdy16, vld16, gt16, eq16, lt16});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_gt_basic;
    int lat;
    rr8 = 1'b1;
    start8(8'hA5, 8'h5A);
    checks++;
    if (rdy8 !== 1'b0) begin
      errors++;
      $display("FAIL accept_ready got=%b required=0", rdy8);
    end
    wait8(lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL gt_latency got=%0d required=8", lat);
    end
    checks++;
    if ({rdy8, gt8, eq8, lt8} !== 4'b0100) begin
      errors++;
      $display("FAIL gt_flags rdy/gt/eq/lt got=%b required=0100",
               {rdy8, gt8, eq8, lt8});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({vld8, rdy8} !== 2'b01) begin
      errors++;
      $display("FAIL gt_pulse valid/ready got=%b required=01", {vld8, rdy8});
    end
  endtask

  task automatic test_hold;
    int lat;
    logic held;
    rr8 = 1'b0;
    start8(8'h3C, 8'h3C);
    wait8(lat);
    checks++;
    if (lat !== 8 || {gt8, eq8, lt8} !== 3'b010) begin
      errors++;
      $display("FAIL eq_result lat=%0d gel=%b required lat=8 gel=010",
               lat, {gt8, eq8, lt8});
    end
    held = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!(vld8 && eq8 && !gt8 && !lt8 && !rdy8)) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL hold_20 got=%b required=1", held);
    end
    @(negedge clk);
    rr8 = 1'b1;
    @(posedge clk);
    #1;
    rr8 = 1'b0;
    checks++;
    if ({vld8, rdy8, eq8} !== 3'b011) begin
      errors++;
      $display("FAIL hold_ack valid/ready/eq got=%b required=011",
               {vld8, rdy8, eq8});
    end
  endtask

  task automatic test_msb_override;
    int lat;
    rr8 = 1'b1;
    start8(8'h80, 8'h7F);
    wait8(lat);
    checks++;
    if (lat !== 8 || {gt8, eq8, lt8} !== 3'b100) begin
      errors++;
      $display("FAIL msb_80_7f lat=%0d gel=%b required lat=8 gel=100",
               lat, {gt8, eq8, lt8});
    end
    @(posedge clk);
    #1;
    start8(8'h01, 8'h02);
    wait8(lat);
    checks++;
    if (lat !== 8 || {gt8, eq8, lt8} !== 3'b001) begin
      errors++;
      $display("FAIL msb_01_02 lat=%0d gel=%b required lat=8 gel=001",
               lat, {gt8, eq8, lt8});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start;
    int lat;
    rr8 = 1'b0;
    start8(8'h5A, 8'h59);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a8  = 8'h00;
    b8  = 8'hFF;
    st8 = 1'b1;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    checks++;
    if (rdy8 !== 1'b0) begin
      errors++;
      $display("FAIL shift_ready got=%b required=0", rdy8);
    end
    wait8(lat);
    checks++;
    if (lat !== 5 || {rdy8, gt8, eq8, lt8} !== 4'b0100) begin
      errors++;
      $display("FAIL ignore_start lat=%0d rgel=%b required lat=5 rgel=0100",
               lat, {rdy8, gt8, eq8, lt8});
    end
    // Start raised in the same cycle the result is acknowledged.
    @(negedge clk);
    rr8 = 1'b1;
    st8 = 1'b1;
    a8  = 8'hFF;
    b8  = 8'h00;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    rr8 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({rdy8, vld8} !== 2'b10) begin
      errors++;
      $display("FAIL ack_start ready/valid got=%b required=10", {rdy8, vld8});
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    rr8 = 1'b1;
    start8(8'h0F, 8'hF0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({rdy8, vld8, gt8, eq8, lt8} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_mid got=%b required=10000",
               {rdy8, vld8, gt8, eq8, lt8});
    end
    @(negedge clk);
    rst = 1'b0;
    start8(8'h10, 8'h10);
    wait8(lat);
    checks++;
    if (lat !== 8 || {gt8, eq8, lt8} !== 3'b010) begin
      errors++;
      $display("FAIL after_reset lat=%0d gel=%b required lat=8 gel=010",
               lat, {gt8, eq8, lt8});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep_n2;
    int lat;
    logic [2:0] exp;
    rr2 = 1'b1;
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        @(negedge clk);
        a2  = 2'(x);
        b2  = 2'(y);
        st2 = 1'b1;
        @(posedge clk);
        #1;
        st2 = 1'b0;
        lat = 0;
        while (!vld2 && lat < 10) begin
          @(posedge clk);
          #1;
          lat++;
        end
        exp = (x > y) ? 3'b100 : (x == y) ? 3'b010 : 3'b001;
        checks++;
        if (lat !== 2 || {gt2, eq2, lt2} !== exp) begin
          errors++;
          $display("FAIL n2_sweep a=%0d b=%0d lat=%0d gel=%b required lat=2 gel=%b",
                   x, y, lat, {gt2, eq2, lt2}, exp);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_sweep_n16;
    int lat;
    logic [2:0] exp;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] dx [4];
    logic [15:0] dy [4];
    dx = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001};
    dy = '{16'h0000, 16'hFFFE, 16'h7FFF, 16'h8000};
    rr16 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 4) begin
        x = dx[i];
        y = dy[i];
      end else begin
        x = 16'($urandom);
        y = (i % 4 == 0) ? x : 16'($urandom);
      end
      @(negedge clk);
      a16  = x;
      b16  = y;
      st16 = 1'b1;
      @(posedge clk);
      #1;
      st16 = 1'b0;
      lat = 0;
      while (!vld16 && lat < 30) begin
        @(posedge clk);
        #1;
        lat++;
      end
      exp = (x > y) ? 3'b100 : (x == y) ? 3'b010 : 3'b001;
      checks++;
      if (lat !== 16 || {gt16, eq16, lt16} !== exp) begin
        errors++;
        $display("FAIL n16_sweep a=%h b=%h lat=%0d gel=%b required lat=16 gel=%b",
                 x, y, lat, {gt16, eq16, lt16}, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_gt_basic();
    test_hold();
    test_msb_override();
    test_ignore_start();
    test_reset_mid();
    test_sweep_n2();
    test_sweep_n16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_greater_than.md
# serial_greater_than

Bit-serial magnitude comparator that evaluates two N-bit unsigned operands LSB-first, one bit per clock, and returns greater-than / equal / less-than flags. It is the sequential, low-area counterpart of the parallel MSB-down comparator cascade in the chapter-2 comparator family. It is intended for datapaths that already stream operands or must trade latency for gate count. Operands are accepted through a start/ready handshake and the result is held under a valid/ready handshake.

## Interface
- N, 8, operand width in bits; legal N ≥ 2
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request to compare a, b; sampled only when ready=1
- a  input  N  operand i0 (unsigned), sampled with start
- b  input  N  operand i1 (unsigned), sampled with start
- ready  output  1  block idle, can accept start
- res_valid  output  1  gt/eq/lt hold a finished result
- res_ready  input  1  consumer acknowledges result
- gt  output  1  a > b
- eq  output  1  a == b
- lt  output  1  a < b

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: ready=1. On start=1, load a, b into shift registers sa, sb; clear running flags g_r=0, l_r=0; clear bit counter cnt=0; go to SHIFT.
- SHIFT: ready=0. Each cycle, examine sa[0], sb[0]:
  - sa[0]=1, sb[0]=0 → g_r=1, l_r=0
  - sa[0]=0, sb[0]=1 → g_r=0, l_r=1
  - otherwise → g_r, l_r unchanged
- In the same cycle, shift sa and sb right by one and increment cnt. Later (more significant) bits override earlier ones.
- When cnt==N-1, the bit being examined is the last one. Write the next-state flags to the outputs: gt=g_next, lt=l_next, eq=~g_next&~l_next. Then go to DONE.
- DONE: res_valid=1, ready=0. When res_ready=1, go to IDLE.
- gt/eq/lt are registered and hold their last result until the next SHIFT→DONE transition.
- Invariant: gt, eq and lt are mutually exclusive whenever res_valid=1.
- Counter width is $clog2(N). cnt never exceeds N-1.

## Timing
- Reset values: state=IDLE, ready=1, res_valid=0, gt=0, eq=0, lt=0, g_r=0, l_r=0, cnt=0.
- Latency: start accepted at edge k; result visible with res_valid=1 after edge k+N; throughput one compare per N+2 cycles minimum.
- res_ready high while res_valid is high: res_valid is a single-cycle pulse and ready returns the following cycle.
- res_ready held low: res_valid and the flags hold indefinitely.
- start while ready=0 (SHIFT or DONE) is ignored. It is not queued.
- start in the same cycle that DONE is acknowledged is ignored, because ready=0 in that cycle.
- a, b changes after acceptance have no effect on the result in progress.
- reset asserted mid-SHIFT or in DONE: immediate return to the reset values; the partial result is discarded.
- res_ready while not in DONE is ignored.

## Structure
- Package sgt_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sgt_state_t
  - localparam functions for the counter width
- Sub-module bit_cmp_cell: combinational 1-bit update.
  - Inputs: ai, bi, g_in, l_in.
  - Outputs: g_out, l_out.
  - Implements the SHIFT-state override rule above.
- Top level contains the FSM, shift registers, counter, result registers and one bit_cmp_cell instance.

## Test plan
- Reset, then a=8'hA5, b=8'h5A, start pulse with res_ready=1 → res_valid pulses exactly 8 cycles after the start edge with gt=1, eq=0, lt=0; ready returns 1 the next cycle.
- a=8'h3C, b=8'h3C, res_ready=0 → eq=1, gt=0, lt=0. res_valid holds for 20 cycles. res_ready=1 for one cycle → IDLE.
- a=8'h80, b=8'h7F → gt=1. Then a=8'h01, b=8'h02 → lt=1. This checks that the MSB override beats the LSB decision.
- Start accepted; at cycle 3 pulse start with new operands a=8'h00, b=8'hFF → ignored, original result delivered; ready=0 throughout SHIFT/DONE.
- Reset asserted during cycle 4 of SHIFT → all outputs 0 and ready=1 immediately. The next compare, a=8'h10, b=8'h10, gives eq=1.
- Parameter sweep with N=2 (exhaustive over all 16 operand pairs) and N=16 (random) against a behavioural a>b / a==b / a<b model → no mismatches; flags one-hot whenever res_valid=1.
